ublock_sbox_serial: RTL and testbench
=====================================

Name: ublock_sbox_serial

Overview:
- Iterative S-box layer for the unmasked uBlock datapath.
- Accepts a full cipher state over a valid/ready handshake and replaces every 4-bit nibble with its uBlock S-box image, LANES nibbles per clock.
- Returns the substituted state over a second valid/ready handshake.
- Sits between the round-key addition and the linear layer; the S-box lanes are the team's NAND/XOR gate network, and this block supplies their sequencing and buffering.

Parameters:
- STATE_W, 128: state width in bits; must be a multiple of 4*LANES.
- LANES, 4: nibbles substituted per clock.
- N_STEPS (localparam), STATE_W/(4*LANES): cycles per state (8 at defaults).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  in_state is valid
- in_ready  output  1  block can accept a state
- in_state  input  STATE_W  state to substitute
- out_valid  output  1  out_state holds a finished result
- out_ready  input  1  consumer accepts out_state
- out_state  output  STATE_W  substituted state
- busy  output  1  high in RUN or DONE

Behaviour:
- Synchronous, active-low reset: rst_n=0 sampled at a clk edge does the following regardless of state, including mid-RUN or while DONE is waiting (the partial state is discarded):
  - FSM goes to IDLE.
  - State register and step counter clear to 0.
  - Output values after reset: in_ready=1, out_valid=0, busy=0, out_state=0.
- S-box, nibble in -> out, hex 0..F: 7,4,9,C,B,A,D,8,F,E,1,6,0,3,2,5. Purely combinational per lane; no bits leak between nibbles.
- Nibble i is state[4i+3:4i].
- Step k (k = 0..N_STEPS-1) substitutes nibbles k*LANES .. k*LANES+LANES-1 in place. Each nibble is substituted exactly once.
- FSM states:
  - IDLE
    - in_ready=1.
    - On in_valid=1 at an edge: load in_state, counter=0, go to RUN.
    - in_valid=0: stay in IDLE.
  - RUN
    - in_ready=0.
    - Each edge applies step counter, then counter+1.
    - On the edge applying step N_STEPS-1: go to DONE; counter wraps to 0.
    - in_valid is ignored in RUN.
  - DONE
    - out_valid=1, and out_state is stable while out_valid=1 and out_ready=0.
    - On out_ready=1 at an edge: go to IDLE.
    - in_ready=0, so no accept happens in the same cycle as output completion.
- out_state continuously reflects the state register. It is meaningful only when out_valid=1.
- Timing:
  - Latency: input accepted at edge E0; out_valid is high after edge E(N_STEPS), i.e. 8 cycles at defaults.
  - Minimum initiation interval: N_STEPS+2 cycles (10 at defaults).
- out_ready while not in DONE: ignored.
- in_valid held high continuously: exactly one load per IDLE visit; no double-load.
- Elaboration must fail (generate-time check) if STATE_W % (4*LANES) != 0.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_n=0 for 3 cycles, release.
  - Required: in_ready=1, out_valid=0, busy=0, out_state=0.
- Basic transform:
  - Stimulus: in_state=0x0123456789ABCDEF0123456789ABCDEF, out_ready=1.
  - Required: out_valid rises exactly 8 edges after acceptance with out_state=0x749CBAD8FE160325749CBAD8FE160325.
- All-zero and all-ones inputs, with exhaustive S-box coverage:
  - 0x00..0 -> 0x77..7.
  - 0xFF..F -> 0x55..5.
  - Sweep a single nibble position through all 16 values and check every other nibble stays at S(0)=7.
- Output backpressure:
  - Stimulus: out_ready=0 for 20 cycles after DONE.
  - Required: out_valid stays 1, out_state is unchanged, in_ready=0, and a new in_valid is not accepted.
  - Then raise out_ready for 1 cycle: IDLE on the next cycle with in_ready=1.
- Reset mid-operation:
  - Stimulus: pull rst_n=0 at RUN step 3.
  - Required: next cycle IDLE, out_state=0, out_valid=0.
  - A subsequent input 0x0123...EF still produces the correct result with 8-cycle latency.
- Back-to-back and parameter sweep:
  - Stimulus: in_valid held high with two states and out_ready=1.
  - Required: results are in order, the initiation interval is 10 cycles, and each block is loaded exactly once.
  - Repeat with LANES=1 (latency 32) and LANES=32 (latency 1); both give identical outputs.

Source files
------------

// File: rtl/ublock_sbox_serial.sv
// Iterative uBlock S-box layer: substitutes LANES nibbles of the held state per clock.
// A state is accepted, processed in N_STEPS cycles, then held until the consumer takes it.
module ublock_sbox_serial #(
    parameter int STATE_W = 128,
    parameter int LANES   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    localparam int N_STEPS = STATE_W / (4 * LANES);
    localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

    generate
        if (STATE_W % (4 * LANES) != 0) begin : g_bad_cfg
            $error("ublock_sbox_serial: STATE_W must be a multiple of 4*LANES");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t               fsm;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_step;
    logic [CNT_W-1:0]   step;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h7;
            4'h1: y = 4'h4;
            4'h2: y = 4'h9;
            4'h3: y = 4'hC;
            4'h4: y = 4'hB;
            4'h5: y = 4'hA;
            4'h6: y = 4'hD;
            4'h7: y = 4'h8;
            4'h8: y = 4'hF;
            4'h9: y = 4'hE;
            4'hA: y = 4'h1;
            4'hB: y = 4'h6;
            4'hC: y = 4'h0;
            4'hD: y = 4'h3;
            4'hE: y = 4'h2;
            default: y = 4'h5;
        endcase
        return y;
    endfunction

    // Only the nibbles belonging to the current step are replaced; the rest pass through.
    always_comb begin
        state_step = state_q;
        for (int j = 0; j < LANES; j++) begin
            state_step[(int'(step) * LANES + j) * 4 +: 4] =
                sbox(state_q[(int'(step) * LANES + j) * 4 +: 4]);
        end
    end

    assign out_state = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            state_q   <= '0;
            step      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_q  <= in_state;
                        step     <= '0;
                        fsm      <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= state_step;
                    if (step == LAST_STEP) begin
                        step      <= '0;
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    // in_ready stays low here so completion and a new accept never share a cycle.
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    step      <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ublock_sbox_serial.sv
// Scoreboard bench for ublock_sbox_serial, run on LANES = 4, 1 and 32 side by side.
// Each configuration has its own driver, reference-model scoreboard and output monitor.
module tb_ublock_sbox_serial;

    localparam int SW = 128;
    localparam logic [3:0] SB [16] = '{4'h7, 4'h4, 4'h9, 4'hC, 4'hB, 4'hA, 4'hD, 4'h8,
                                       4'hF, 4'hE, 4'h1, 4'h6, 4'h0, 4'h3, 4'h2, 4'h5};
    localparam logic [SW-1:0] VEC_A = 128'h0123456789ABCDEF0123456789ABCDEF;

    logic     clk = 1'b0;
    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;
    bit [2:0] done = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [SW-1:0] model(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        for (int i = 0; i < SW / 4; i++) r[4*i +: 4] = SB[s[4*i +: 4]];
        return r;
    endfunction

    typedef struct {
        logic [SW-1:0] st;
        int            acc;
    } exp_t;

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int L = (g == 0) ? 4 : ((g == 1) ? 1 : 32);
        localparam int N = SW / (4 * L);
        localparam int RST_STEP = (N > 3) ? 3 : 0;

        logic          rst_n, in_valid, in_ready, out_valid, out_ready, busy;
        logic [SW-1:0] in_state, out_state;
        exp_t          q[$];
        logic [SW-1:0] held;
        bit            prev_valid = 1'b0;
        int            last_acc = 0;

        ublock_sbox_serial #(.STATE_W(SW), .LANES(L)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
            .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
            .out_state(out_state), .busy(busy)
        );

        task automatic chk(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL [L=%0d] %s: got %h, expected %h", L, name, got, exp);
            end
        endtask

        task automatic chk_idle(input string tag);
            chk({tag, " in_ready"}, SW'(in_ready), SW'(1));
            chk({tag, " out_valid"}, SW'(out_valid), SW'(0));
            chk({tag, " busy"}, SW'(busy), SW'(0));
        endtask

        // Called at a negedge; returns at the negedge right after the accepting edge.
        task automatic send(input logic [SW-1:0] s, input bit hold, input bit rnd_rdy);
            bit ok = 1'b0;
            in_state = s;
            in_valid = 1'b1;
            for (int k = 0; k < 300 && !ok; k++) begin
                if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
                if (in_ready) begin
                    q.push_back('{st: model(s), acc: cyc + 1});
                    last_acc = cyc + 1;
                    ok = 1'b1;
                end
                @(negedge clk);
            end
            if (!ok) chk("accept timeout", 0, 1);
            if (!hold) in_valid = 1'b0;
        endtask

        task automatic drain();
            out_ready = 1'b1;
            for (int k = 0; k < 300 && (q.size() != 0 || out_valid); k++) @(negedge clk);
            chk("drain pending", SW'(q.size()), 0);
        endtask

        always @(negedge clk) begin
            if (!rst_n) begin
                prev_valid <= 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected output", out_state, 'x);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        held = e.st;
                        chk("result", out_state, e.st);
                        chk("latency", SW'(cyc - e.acc), SW'(N));
                    end
                end else if (out_valid && prev_valid) begin
                    chk("held result", out_state, held);
                end
                prev_valid <= out_valid;
            end
        end

        initial begin
            int acc_a;
            logic [SW-1:0] s;
            rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            chk_idle("reset");
            chk("reset out_state", out_state, '0);
            @(negedge clk);

            out_ready = 1'b1;
            send(VEC_A, 0, 0);
            send('0, 0, 0);
            send('1, 0, 0);
            for (int v = 0; v < 16; v++) begin
                int pos = $urandom_range(0, SW / 4 - 1);
                s = '0;
                s[4*pos +: 4] = 4'(v);
                send(s, 0, 0);
            end
            drain();

            out_ready = 1'b0;
            send({$urandom, $urandom, $urandom, $urandom}, 0, 0);
            for (int k = 0; k < 100 && !out_valid; k++) @(negedge clk);
            for (int k = 0; k < 20; k++) begin
                in_valid = 1'b1;
                in_state = {$urandom, $urandom, $urandom, $urandom};
                chk("bp out_valid", SW'(out_valid), SW'(1));
                chk("bp in_ready", SW'(in_ready), SW'(0));
                @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk_idle("after release");
            drain();

            send(VEC_A, 0, 0);
            repeat (RST_STEP) @(negedge clk);
            rst_n = 1'b0;
            q.delete();
            @(negedge clk);
            chk_idle("mid reset");
            chk("mid reset out_state", out_state, '0);
            rst_n = 1'b1;
            @(negedge clk);
            send(VEC_A, 0, 0);
            drain();

            send({$urandom, $urandom, $urandom, $urandom}, 1, 0);
            acc_a = last_acc;
            send({$urandom, $urandom, $urandom, $urandom}, 1, 0);
            chk("initiation interval", SW'(last_acc - acc_a), SW'(N + 2));
            in_valid = 1'b0;
            drain();

            for (int t = 0; t < 20; t++) begin
                send({$urandom, $urandom, $urandom, $urandom}, 0, 1);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            drain();
            repeat (3) @(negedge clk);
            done[g] = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && done != 3'b111; i++) @(posedge clk);
        checks++;
        if (done != 3'b111) begin
            errors++;
            $display("FAIL completion: done flags %b, expected 111", done);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
